// File: rtl/fog_plant_emu.sv
// Fiber-optic gyro plant emulator: delayed modulation status drives an ADC sample model
// with edge-triggered transients. Optional LFSR noise is enabled with FOG_EMU_NOISE_EN.
module fog_plant_emu (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_status,
  input  logic        i_polarity,
  input  logic [5:0]  i_delay_cnt,
  input  logic [13:0] i_adc_base,
  input  logic [13:0] i_rate,
  input  logic [7:0]  i_glitch_len,
  input  logic [13:0] i_glitch_amp,
  output logic [13:0] o_adc_data,
  output logic        o_adc_valid,
  output logic        o_dly_status,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GLITCH = 2'd1,
    STEADY = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [63:0]        dline;
  logic [5:0]         wr_ptr, rd_ptr;
  logic               ds, ds_prev, edge_det;
  logic [7:0]         cnt, cnt_nx;
  logic signed [16:0] rate_ext, rate_term, sum;
  logic [13:0]        sample;

  // Entry written D+1 clocks ago; D=63 reads the slot about to be overwritten.
  assign rd_ptr       = wr_ptr - 6'd1 - i_delay_cnt;
  assign ds           = dline[rd_ptr];
  assign edge_det     = ds ^ ds_prev;
  assign o_dly_status = ds;
  assign o_state      = state;

`ifdef FOG_EMU_NOISE_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (edge_det) begin
      if (i_glitch_len != 8'd0) begin
        state_nx = GLITCH;
        cnt_nx   = i_glitch_len - 8'd1;
      end else begin
        state_nx = STEADY;
      end
    end else begin
      case (state)
        IDLE:    state_nx = IDLE;
        GLITCH:  if (cnt == 8'd0) state_nx = STEADY;
                 else cnt_nx = cnt - 8'd1;
        STEADY:  state_nx = STEADY;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Sample is built from the next state so edge, sign and transient land in one register stage.
  always_comb begin
    rate_ext  = $signed({{3{i_rate[13]}}, i_rate});
    rate_term = (ds ^ i_polarity) ? rate_ext : -rate_ext;
    sum       = $signed({3'b000, i_adc_base});
    if (state_nx != IDLE) sum = sum + rate_term;
    if (state_nx == GLITCH) sum = sum - $signed({3'b000, i_glitch_amp});
`ifdef FOG_EMU_NOISE_EN
    sum = sum + $signed({{13{lfsr[3]}}, lfsr[3:0]});
`endif
    if (sum < 17'sd0)
      sample = '0;
    else if (sum > 17'sd16383)
      sample = '1;
    else
      sample = sum[13:0];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      dline       <= '0;
      wr_ptr      <= '0;
      ds_prev     <= 1'b0;
      state       <= IDLE;
      cnt         <= '0;
      o_adc_data  <= '0;
      o_adc_valid <= 1'b0;
    end else begin
      dline[wr_ptr] <= i_status;
      wr_ptr        <= wr_ptr + 6'd1;
      ds_prev       <= ds;
      state         <= state_nx;
      cnt           <= cnt_nx;
      o_adc_data    <= sample;
      o_adc_valid   <= 1'b1;
    end
  end

`ifdef FOG_EMU_NOISE_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) lfsr <= 16'hACE1;
    else          lfsr <= {lfsr_fb, lfsr[15:1]};
  end
`endif

endmodule
